// File: rtl/pll_ctrl_pkg.sv
// Shared types for the ECP5 PLL phase-shift sequencer: FSM states, PHASESEL
// encodings and a small constant-evaluation helper.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_IDLE      = 3'd2,
    ST_SETUP     = 3'd3,
    ST_STEP_LO   = 3'd4,
    ST_STEP_HI   = 3'd5,
    ST_SETTLE    = 3'd6,
    ST_DONE      = 3'd7
  } state_e;

  localparam logic [1:0] SEL_CLKOS  = 2'b00;
  localparam logic [1:0] SEL_CLKOS2 = 2'b01;
  localparam logic [1:0] SEL_CLKOS3 = 2'b10;
  localparam logic [1:0] SEL_CLKOP  = 2'b11;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Double-register the asynchronous input into the i_clk domain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_phase_ctrl.sv
// EHXPLLL sequencer: holds the PLL in reset, waits for lock, then runs dynamic
// phase-shift commands on PHASESEL/PHASEDIR/PHASESTEP while watching lock.
module pll_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int SETUP_CYCLES   = 2,
  parameter int STEP_LO_CYCLES = 2,
  parameter int STEP_HI_CYCLES = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int STEPS_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_sel,
  input  logic               req_dir,
  input  logic [STEPS_W-1:0] req_steps,
  output logic               done,
  output logic               abort,
  output logic               busy,
  output logic               locked,
  output logic               lock_err,
  input  logic               pll_lock,
  output logic               pll_rst,
  output logic [1:0]         phasesel,
  output logic               phasedir,
  output logic               phasestep,
  output logic               phaseloadreg
);

  localparam int MAX_CYC = max2(max2(max2(RST_CYCLES, LOCK_TIMEOUT),
                                     max2(SETUP_CYCLES, STEP_LO_CYCLES)),
                                max2(STEP_HI_CYCLES, SETTLE_CYCLES));
  localparam int CW = $clog2(MAX_CYC) + 1;

  // Each timed state is entered with duration-1 and leaves when the count hits 0.
  localparam logic [CW-1:0] LD_RST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LD_LOCK   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] LD_SETUP  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] LD_LO     = CW'(STEP_LO_CYCLES - 1);
  localparam logic [CW-1:0] LD_HI     = CW'(STEP_HI_CYCLES - 1);
  localparam logic [CW-1:0] LD_SETTLE = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [STEPS_W-1:0] STEP_ZERO = {STEPS_W{1'b0}};
  localparam logic [STEPS_W-1:0] STEP_ONE  = {{(STEPS_W-1){1'b0}}, 1'b1};

  state_e             r_state;
  logic [CW-1:0]      r_cnt;
  logic [STEPS_W-1:0] r_remaining;
  logic               w_lock_s;
  logic               w_in_flight;
  logic               w_lock_lost;

  sync_2ff u_lock_sync (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (pll_lock),
    .o_q   (w_lock_s)
  );

  assign w_in_flight = (r_state == ST_SETUP)   || (r_state == ST_STEP_LO) ||
                       (r_state == ST_STEP_HI) || (r_state == ST_SETTLE)  ||
                       (r_state == ST_DONE);
  assign w_lock_lost = !w_lock_s && (w_in_flight || (r_state == ST_IDLE));
  assign req_ready   = (r_state == ST_IDLE) && w_lock_s;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RST_PLL;
      r_cnt        <= LD_RST;
      r_remaining  <= STEP_ZERO;
      pll_rst      <= 1'b1;
      phasestep    <= 1'b1;
      phaseloadreg <= 1'b1;
      phasedir     <= 1'b0;
      phasesel     <= SEL_CLKOS;
      done         <= 1'b0;
      abort        <= 1'b0;
      locked       <= 1'b0;
      lock_err     <= 1'b0;
      busy         <= 1'b1;
    end else begin
      done         <= 1'b0;
      abort        <= 1'b0;
      locked       <= w_lock_s;
      phaseloadreg <= 1'b1;
      if (w_lock_lost) begin
        // Lock loss pre-empts everything, including a half-finished low pulse.
        r_state   <= ST_RST_PLL;
        r_cnt     <= LD_RST;
        pll_rst   <= 1'b1;
        phasestep <= 1'b1;
        busy      <= 1'b1;
        abort     <= w_in_flight;
      end else begin
        case (r_state)
          ST_RST_PLL: begin
            if (r_cnt == CNT_ZERO) begin
              r_state <= ST_WAIT_LOCK;
              r_cnt   <= LD_LOCK;
              pll_rst <= 1'b0;
            end else begin
              r_cnt <= r_cnt - CNT_ONE;
            end
          end
          ST_WAIT_LOCK: begin
            if (w_lock_s) begin
              r_state <= ST_IDLE;
              busy    <= 1'b0;
            end else if (r_cnt == CNT_ZERO) begin
              r_state  <= ST_RST_PLL;
              r_cnt    <= LD_RST;
              pll_rst  <= 1'b1;
              lock_err <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_ONE;
            end
          end
          ST_IDLE: begin
            if (req_valid && req_ready) begin
              phasesel    <= req_sel;
              phasedir    <= req_dir;
              r_remaining <= req_steps;
              busy        <= 1'b1;
              r_cnt       <= LD_SETUP;
              r_state     <= (req_steps == STEP_ZERO) ? ST_DONE : ST_SETUP;
            end
          end
          ST_SETUP: begin
            if (r_cnt == CNT_ZERO) begin
              r_state     <= ST_STEP_LO;
              r_cnt       <= LD_LO;
              phasestep   <= 1'b0;
              r_remaining <= r_remaining - STEP_ONE;
            end else begin
              r_cnt <= r_cnt - CNT_ONE;
            end
          end
          ST_STEP_LO: begin
            if (r_cnt == CNT_ZERO) begin
              r_state   <= ST_STEP_HI;
              r_cnt     <= LD_HI;
              phasestep <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_ONE;
            end
          end
          ST_STEP_HI: begin
            if (r_cnt != CNT_ZERO) begin
              r_cnt <= r_cnt - CNT_ONE;
            end else if (r_remaining != STEP_ZERO) begin
              r_state     <= ST_STEP_LO;
              r_cnt       <= LD_LO;
              phasestep   <= 1'b0;
              r_remaining <= r_remaining - STEP_ONE;
            end else begin
              r_state <= ST_SETTLE;
              r_cnt   <= LD_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (r_cnt == CNT_ZERO) begin
              r_state <= ST_DONE;
            end else begin
              r_cnt <= r_cnt - CNT_ONE;
            end
          end
          ST_DONE: begin
            // done is raised on leaving DONE so a lock loss here can suppress it.
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: begin
            r_state   <= ST_RST_PLL;
            r_cnt     <= LD_RST;
            pll_rst   <= 1'b1;
            phasestep <= 1'b1;
            busy      <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Self-checking bench for pll_phase_ctrl: PLL lock model, randomized phase
// commands and a cycle-index reference of the expected PHASESTEP waveform.
module tb_pll_phase_ctrl;
  import pll_ctrl_pkg::*;

  localparam int T_RST      = 16;
  localparam int T_TO       = 100;
  localparam int T_SETUP    = 2;
  localparam int T_LO       = 2;
  localparam int T_HI       = 4;
  localparam int T_SETTLE   = 8;
  localparam int LOCK_DELAY = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_sel = 2'b00;
  logic       req_dir = 1'b0;
  logic [7:0] req_steps = 8'd0;
  logic       done, abort, busy, locked, lock_err;
  logic       pll_lock, pll_rst;
  logic [1:0] phasesel;
  logic       phasedir, phasestep, phaseloadreg;

  logic model_lock = 1'b0;
  logic lock_en = 1'b1;
  int   model_cnt = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  pll_phase_ctrl #(.LOCK_TIMEOUT(T_TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_dir(req_dir), .req_steps(req_steps),
    .done(done), .abort(abort), .busy(busy), .locked(locked), .lock_err(lock_err),
    .pll_lock(pll_lock), .pll_rst(pll_rst), .phasesel(phasesel),
    .phasedir(phasedir), .phasestep(phasestep), .phaseloadreg(phaseloadreg)
  );

  always #5 clk = ~clk;

  // PLL model: locks LOCK_DELAY cycles after its reset is released.
  assign pll_lock = model_lock & lock_en;
  always @(posedge clk) begin
    #1;
    if (pll_rst === 1'b1) begin
      model_cnt  = 0;
      model_lock = 1'b0;
    end else begin
      model_cnt++;
      if (model_cnt >= LOCK_DELAY) model_lock = 1'b1;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected PHASESTEP at sample idx after the accepting edge.
  function automatic logic exp_step(input int idx, input int steps);
    int k;
    if (steps == 0 || idx < T_SETUP || idx >= T_SETUP + steps * (T_LO + T_HI)) return 1'b1;
    k = (idx - T_SETUP) % (T_LO + T_HI);
    return (k < T_LO) ? 1'b0 : 1'b1;
  endfunction

  function automatic int done_idx(input int steps);
    return (steps == 0) ? 1 : T_SETUP + steps * (T_LO + T_HI) + T_SETTLE + 1;
  endfunction

  task automatic run_cmd(input logic [1:0] sel, input logic dir, input int steps,
                         input bit hold, input string name, output int waited);
    int idx, dexp, seen, stepbad, selbad, rdybad;
    req_sel = sel; req_dir = dir; req_steps = 8'(steps); req_valid = 1'b1;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 500) begin tick(); waited++; end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s accept: req_ready=%b, required 1", name, req_ready);
      req_valid = 1'b0;
      return;
    end
    tick();
    if (!hold) req_valid = 1'b0;
    dexp = done_idx(steps); seen = -1; stepbad = 0; selbad = 0; rdybad = 0; idx = 0;
    while (idx <= dexp + 20) begin
      if (done === 1'b1) begin seen = idx; break; end
      if (abort === 1'b1) break;
      if (phasestep !== exp_step(idx, steps)) stepbad++;
      if (steps != 0 && (phasesel !== sel || phasedir !== dir)) selbad++;
      if (req_ready !== 1'b0 || busy !== 1'b1) rdybad++;
      tick(); idx++;
    end
    n_cmp++;
    if (seen != dexp) begin n_err++; $display("FAIL %s done_cycle: got %0d, required %0d", name, seen, dexp); end
    n_cmp++;
    if (stepbad != 0) begin n_err++; $display("FAIL %s phasestep: %0d bad cycles, required 0", name, stepbad); end
    n_cmp++;
    if (selbad != 0) begin n_err++; $display("FAIL %s sel_dir: %0d bad cycles, required 0", name, selbad); end
    n_cmp++;
    if (rdybad != 0) begin n_err++; $display("FAIL %s ready_busy: %0d bad cycles, required 0", name, rdybad); end
    n_cmp++;
    if ({busy, req_ready, phasestep} !== 3'b011) begin
      n_err++; $display("FAIL %s at_done: busy/ready/step=%b, required 011", name, {busy, req_ready, phasestep});
    end
  endtask

  task automatic test_reset();
    int n;
    repeat (3) tick();
    n_cmp++;
    if ({pll_rst, phasestep, phaseloadreg, phasedir, phasesel, done, abort, locked, lock_err, busy}
        !== 11'b111_0_00_0000_1) begin
      n_err++; $display("FAIL reset_values: got %b, required 11100000001",
        {pll_rst, phasestep, phaseloadreg, phasedir, phasesel, done, abort, locked, lock_err, busy});
    end
    reset = 1'b0;
    n = 0;
    while (pll_rst === 1'b1 && n < 1000) begin n++; tick(); end
    n_cmp++;
    if (n != T_RST) begin n_err++; $display("FAIL pll_rst_width: got %0d, required %0d", n, T_RST); end
    n = 0;
    while (pll_lock !== 1'b1 && n < 200) begin n++; tick(); end
    tick(); tick();
    n_cmp++;
    if (locked !== 1'b0) begin n_err++; $display("FAIL lock_sync_early: locked=%b, required 0", locked); end
    tick();
    n_cmp++;
    if ({locked, req_ready, busy, lock_err} !== 4'b1100) begin
      n_err++; $display("FAIL lock_up: locked/ready/busy/err=%b, required 1100", {locked, req_ready, busy, lock_err});
    end
  endtask

  task automatic test_cmd();
    int w;
    run_cmd(SEL_CLKOP, 1'b1, 3, 1'b0, "cmd3", w);
    repeat (3) tick();
    run_cmd(SEL_CLKOS2, 1'b0, 255, 1'b0, "cmd255", w);
  endtask

  task automatic test_zero_steps();
    int w;
    tick();
    run_cmd(SEL_CLKOS3, 1'b1, 0, 1'b0, "zero", w);
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      run_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 6), 1'b0, "rand", w);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    tick();
    run_cmd(SEL_CLKOS, 1'b1, 2, 1'b1, "b2b_first", w);
    run_cmd(SEL_CLKOS3, 1'b0, 1, 1'b0, "b2b_second", w);
    n_cmp++;
    if (w != 0) begin n_err++; $display("FAIL b2b_accept_delay: got %0d, required 0", w); end
  endtask

  task automatic test_lock_loss();
    int ab_idx, n_ab, n_done, lows, n;
    logic ab_step, ab_rst;
    tick();
    req_sel = SEL_CLKOS2; req_dir = 1'b0; req_steps = 8'd5; req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin tick(); n++; end
    tick();
    req_valid = 1'b0;
    ab_idx = -1; n_ab = 0; n_done = 0; lows = 0; ab_step = 1'b0; ab_rst = 1'b0;
    for (int idx = 0; idx < 40; idx++) begin
      if (abort === 1'b1) begin
        if (ab_idx < 0) begin ab_idx = idx; ab_step = phasestep; ab_rst = pll_rst; end
        n_ab++;
      end
      if (done === 1'b1) n_done++;
      if (ab_idx < 0 && phasestep === 1'b0) lows++;
      if (idx == 6) lock_en = 1'b0;
      tick();
    end
    n_cmp++;
    if (ab_idx != 9) begin n_err++; $display("FAIL abort_cycle: got %0d, required 9", ab_idx); end
    n_cmp++;
    if ({ab_step, ab_rst} !== 2'b11) begin n_err++; $display("FAIL abort_outputs: step/rst=%b, required 11", {ab_step, ab_rst}); end
    n_cmp++;
    if (n_ab != 1 || n_done != 0) begin n_err++; $display("FAIL abort_pulse: aborts=%0d dones=%0d, required 1 0", n_ab, n_done); end
    n_cmp++;
    if (lows != 3) begin n_err++; $display("FAIL abort_lows: got %0d, required 3", lows); end
    lock_en = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 300) begin tick(); n++; end
    n_cmp++;
    if ({req_ready, locked, lock_err} !== 3'b110) begin
      n_err++; $display("FAIL relock: ready/locked/err=%b, required 110", {req_ready, locked, lock_err});
    end
  endtask

  task automatic test_timeout();
    int n, hi, lo, n_ab;
    logic err_early;
    lock_en = 1'b0;
    n = 0; n_ab = 0;
    while (pll_rst !== 1'b1 && n < 20) begin if (abort === 1'b1) n_ab++; tick(); n++; end
    n_cmp++;
    if (n_ab != 0 || pll_rst !== 1'b1) begin
      n_err++; $display("FAIL idle_lock_loss: aborts=%0d pll_rst=%b, required 0 1", n_ab, pll_rst);
    end
    for (int r = 0; r < 2; r++) begin
      hi = 0; lo = 0; err_early = 1'b0;
      while (pll_rst === 1'b1 && hi < 1000) begin hi++; tick(); end
      while (pll_rst === 1'b0 && lo < 1000) begin
        if (r == 0 && lock_err !== 1'b0) err_early = 1'b1;
        lo++; tick();
      end
      n_cmp++;
      if (hi != T_RST || lo != T_TO) begin
        n_err++; $display("FAIL retry%0d_timing: rst=%0d wait=%0d, required %0d %0d", r, hi, lo, T_RST, T_TO);
      end
      n_cmp++;
      if (lock_err !== 1'b1 || err_early) begin
        n_err++; $display("FAIL retry%0d_lock_err: got %b early=%b, required 1 0", r, lock_err, err_early);
      end
    end
    lock_en = 1'b1;
    n = 0;
    while (locked !== 1'b1 && n < 400) begin tick(); n++; end
    tick();
    n_cmp++;
    if ({locked, req_ready, lock_err} !== 3'b111) begin
      n_err++; $display("FAIL sticky_lock_err: locked/ready/err=%b, required 111", {locked, req_ready, lock_err});
    end
  endtask

  initial begin
    test_reset();
    test_cmd();
    test_zero_steps();
    test_random();
    test_back_to_back();
    test_lock_loss();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
